// File: rtl/scanner_lot_sequencer.sv
// -----------------------------------------------------------------------------
// scanner_lot_sequencer
//
// Lot-level controller sitting above the scanner FSM. For every wafer it
// issues one scan_start pulse, then follows the scanner's current_process code
// through "left IDLE", "reached UNLOAD" and "back at IDLE". Completed wafers
// are counted. A wafer that ends in ERROR is reissued up to MAX_RETRY times
// per lot. Every phase is guarded by a watchdog.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   lot_start     lot request, honoured only while idle
//   lot_size      wafers in the lot, latched when a lot is accepted
//   abort         level; cancels a running lot or clears a fault
//   scan_process  scanner current_process code
//   scan_start    one-cycle start pulse to the scanner (op_start_btn)
//   lot_busy      high while a lot is being worked
//   lot_done      one-cycle pulse when the lot completes
//   lot_fault     high while the sequencer is parked in its fault state
//   fault_code    0 none, 1 ack timeout, 2 run timeout,
//                 3 retries exhausted, 4 IDLE reached without UNLOAD
//   wafer_idx     wafers completed in the current lot
//   retry_cnt     errors absorbed in the current lot
// -----------------------------------------------------------------------------
module scanner_lot_sequencer #(
    parameter logic [3:0]  P_IDLE    = 4'd0,
    parameter logic [3:0]  P_UNLOAD  = 4'd7,
    parameter logic [3:0]  P_ERROR   = 4'd8,
    parameter logic [15:0] ACK_TO    = 16'd16,
    parameter logic [15:0] RUN_TO    = 16'd4000,
    parameter logic [7:0]  GAP_CYC   = 8'd4,
    parameter logic [1:0]  MAX_RETRY = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lot_start,
    input  logic [7:0] lot_size,
    input  logic       abort,
    input  logic [3:0] scan_process,
    output logic       scan_start,
    output logic       lot_busy,
    output logic       lot_done,
    output logic       lot_fault,
    output logic [2:0] fault_code,
    output logic [7:0] wafer_idx,
    output logic [1:0] retry_cnt
);

    // The low four bits of each state code are the output flags
    // {scan_start, lot_busy, lot_done, lot_fault}, so these outputs come
    // straight off flops with no decode logic behind them.
    typedef enum logic [6:0] {
        S_IDLE     = 7'b000_0000,
        S_ISSUE    = 7'b001_1100,
        S_WAIT_ACK = 7'b010_0100,
        S_RUN      = 7'b011_0100,
        S_RECOVER  = 7'b100_0100,
        S_GAP      = 7'b101_0100,
        S_DONE     = 7'b110_0010,
        S_FAULT    = 7'b111_0001
    } state_t;

    state_t      state_r;
    logic [7:0]  size_r;
    logic [7:0]  wafer_idx_r;
    logic [1:0]  retry_cnt_r;
    logic [2:0]  fault_code_r;
    logic [15:0] timer_r;
    logic [7:0]  gap_cnt_r;
    logic        seen_unload_r;

    logic [16:0] timer_inc_s;
    logic [8:0]  gap_inc_s;
    logic        ack_expired_s;
    logic        run_expired_s;
    logic        gap_over_s;
    logic        retry_full_s;
    logic [7:0]  wafer_next_s;

    // A watchdog fires on the cycle whose increment would reach the limit,
    // so a phase may last at most ACK_TO / RUN_TO cycles.
    assign timer_inc_s   = {1'b0, timer_r} + 17'd1;
    assign ack_expired_s = (timer_inc_s >= {1'b0, ACK_TO});
    assign run_expired_s = (timer_inc_s >= {1'b0, RUN_TO});
    // GAP always lasts at least one cycle, which also covers GAP_CYC == 0.
    assign gap_inc_s     = {1'b0, gap_cnt_r} + 9'd1;
    assign gap_over_s    = (gap_inc_s >= {1'b0, GAP_CYC});
    assign retry_full_s  = (retry_cnt_r >= MAX_RETRY);
    assign wafer_next_s  = (wafer_idx_r == 8'hFF) ? 8'hFF : (wafer_idx_r + 8'd1);

    assign scan_start = state_r[3];
    assign lot_busy   = state_r[2];
    assign lot_done   = state_r[1];
    assign lot_fault  = state_r[0];
    assign fault_code = fault_code_r;
    assign wafer_idx  = wafer_idx_r;
    assign retry_cnt  = retry_cnt_r;

    // Lot sequencing FSM together with its counters and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            size_r        <= 8'd0;
            wafer_idx_r   <= 8'd0;
            retry_cnt_r   <= 2'd0;
            fault_code_r  <= 3'd0;
            timer_r       <= 16'd0;
            gap_cnt_r     <= 8'd0;
            seen_unload_r <= 1'b0;
        end else if (abort && (state_r != S_IDLE)) begin
            // abort beats every other transition, timeouts included
            state_r      <= S_IDLE;
            fault_code_r <= 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (lot_start && !abort) begin
                        size_r       <= lot_size;
                        wafer_idx_r  <= 8'd0;
                        retry_cnt_r  <= 2'd0;
                        fault_code_r <= 3'd0;
                        state_r      <= (lot_size == 8'd0) ? S_DONE : S_ISSUE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    timer_r       <= 16'd0;
                    seen_unload_r <= 1'b0;
                    state_r       <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (scan_process == P_ERROR) begin
                        if (retry_full_s) begin
                            fault_code_r <= 3'd3;
                            state_r      <= S_FAULT;
                        end else begin
                            retry_cnt_r <= retry_cnt_r + 2'd1;
                            timer_r     <= 16'd0;
                            state_r     <= S_RECOVER;
                        end
                    end else if (scan_process != P_IDLE) begin
                        timer_r <= 16'd0;
                        state_r <= S_RUN;
                    end else if (ack_expired_s) begin
                        fault_code_r <= 3'd1;
                        state_r      <= S_FAULT;
                    end else begin
                        timer_r <= timer_inc_s[15:0];
                    end
                end
                S_RUN: begin
                    if (scan_process == P_ERROR) begin
                        if (retry_full_s) begin
                            fault_code_r <= 3'd3;
                            state_r      <= S_FAULT;
                        end else begin
                            retry_cnt_r <= retry_cnt_r + 2'd1;
                            timer_r     <= 16'd0;
                            state_r     <= S_RECOVER;
                        end
                    end else if (scan_process == P_IDLE) begin
                        if (seen_unload_r) begin
                            wafer_idx_r <= wafer_next_s;
                            gap_cnt_r   <= 8'd0;
                            state_r     <= (wafer_next_s >= size_r) ? S_DONE : S_GAP;
                        end else begin
                            fault_code_r <= 3'd4;
                            state_r      <= S_FAULT;
                        end
                    end else if (run_expired_s) begin
                        fault_code_r <= 3'd2;
                        state_r      <= S_FAULT;
                    end else begin
                        timer_r <= timer_inc_s[15:0];
                        if (scan_process == P_UNLOAD) begin
                            seen_unload_r <= 1'b1;
                        end else begin
                            seen_unload_r <= seen_unload_r;
                        end
                    end
                end
                S_RECOVER: begin
                    // wafer_idx untouched: the same wafer is issued again
                    if (scan_process == P_IDLE) begin
                        gap_cnt_r <= 8'd0;
                        state_r   <= S_GAP;
                    end else if (run_expired_s) begin
                        fault_code_r <= 3'd2;
                        state_r      <= S_FAULT;
                    end else begin
                        timer_r <= timer_inc_s[15:0];
                    end
                end
                S_GAP: begin
                    if (gap_over_s) begin
                        state_r <= S_ISSUE;
                    end else begin
                        gap_cnt_r <= gap_inc_s[7:0];
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                S_FAULT: begin
                    // sticky until abort, which is handled above
                    state_r <= S_FAULT;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scanner_lot_sequencer.sv
module tb_scanner_lot_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       lot_start;
    logic [7:0] lot_size;
    logic       abort;
    logic [3:0] scan_process;
    logic       scan_start;
    logic       lot_busy;
    logic       lot_done;
    logic       lot_fault;
    logic [2:0] fault_code;
    logic [7:0] wafer_idx;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    scanner_lot_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .lot_start    (lot_start),
        .lot_size     (lot_size),
        .abort        (abort),
        .scan_process (scan_process),
        .scan_start   (scan_start),
        .lot_busy     (lot_busy),
        .lot_done     (lot_done),
        .lot_fault    (lot_fault),
        .fault_code   (fault_code),
        .wafer_idx    (wafer_idx),
        .retry_cnt    (retry_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference of the lot rules ----------------
    localparam int PH_READY = 0, PH_START = 1, PH_ACK = 2, PH_BUSY = 3,
                   PH_ERR = 4, PH_PAUSE = 5, PH_FIN = 6, PH_STUCK = 7;
    localparam int ACK_LIMIT = 16, RUN_LIMIT = 4000, GAP_LEN = 4, RETRY_LIMIT = 2;

    int         ph = PH_READY;
    int         m_wait = 0;
    int         m_pause = 0;
    bit         m_unload = 1'b0;
    logic [7:0] m_size = 8'd0;
    logic [7:0] m_done = 8'd0;
    logic [1:0] m_retries = 2'd0;
    logic [2:0] m_code = 3'd0;

    function automatic logic [16:0] expected();
        logic s, b, d, f;
        s = (ph == PH_START);
        d = (ph == PH_FIN);
        f = (ph == PH_STUCK);
        b = !((ph == PH_READY) || d || f);
        return {s, b, d, f, m_code, m_done, m_retries};
    endfunction

    function automatic bit model_settled();
        return (ph == PH_READY) || (ph == PH_STUCK);
    endfunction

    task automatic go_fault(input logic [2:0] c);
        m_code = c;
        ph = PH_STUCK;
    endtask

    task automatic scanner_error();
        if (m_retries == 2'(RETRY_LIMIT)) go_fault(3'd3);
        else begin
            m_retries = m_retries + 2'd1;
            m_wait = 0;
            ph = PH_ERR;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            ph = PH_READY; m_wait = 0; m_pause = 0; m_unload = 1'b0;
            m_size = 8'd0; m_done = 8'd0; m_retries = 2'd0; m_code = 3'd0;
        end else if (abort && ph != PH_READY) begin
            ph = PH_READY;
            m_code = 3'd0;
        end else begin
            case (ph)
                PH_READY: if (lot_start && !abort) begin
                    m_size = lot_size; m_done = 8'd0; m_retries = 2'd0; m_code = 3'd0;
                    ph = (lot_size == 8'd0) ? PH_FIN : PH_START;
                end
                PH_START: begin m_wait = 0; m_unload = 1'b0; ph = PH_ACK; end
                PH_ACK: begin
                    m_wait++;
                    if (scan_process == 4'd8) scanner_error();
                    else if (scan_process != 4'd0) begin m_wait = 0; ph = PH_BUSY; end
                    else if (m_wait >= ACK_LIMIT) go_fault(3'd1);
                end
                PH_BUSY: begin
                    m_wait++;
                    if (scan_process == 4'd8) scanner_error();
                    else if (scan_process == 4'd0) begin
                        if (!m_unload) go_fault(3'd4);
                        else begin
                            m_done = m_done + 8'd1;
                            if (m_done == m_size) ph = PH_FIN;
                            else begin m_pause = 0; ph = PH_PAUSE; end
                        end
                    end else if (m_wait >= RUN_LIMIT) go_fault(3'd2);
                    else if (scan_process == 4'd7) m_unload = 1'b1;
                end
                PH_ERR: begin
                    m_wait++;
                    if (scan_process == 4'd0) begin m_pause = 0; ph = PH_PAUSE; end
                    else if (m_wait >= RUN_LIMIT) go_fault(3'd2);
                end
                PH_PAUSE: begin
                    m_pause++;
                    if (m_pause >= GAP_LEN) ph = PH_START;
                end
                PH_FIN: ph = PH_READY;
                default: ;
            endcase
        end
    endtask

    // ---------------- scanner stimulus ----------------
    localparam int MODE_NORMAL = 0, MODE_ERR_AT = 1, MODE_ERR_ALL = 2, MODE_NOACK = 3,
                   MODE_STUCK = 4, MODE_SKIP = 5, MODE_RAND = 6;
    int         mode = MODE_NORMAL;
    int         err_issue = 0;
    int         issue_no = 0;
    logic [3:0] scn_q[$];

    task automatic build_seq();
        int  d, k;
        bit  err, skip;
        scn_q.delete();
        d = $urandom_range(0, 2);
        k = 3;
        err = 1'b0;
        skip = 1'b0;
        case (mode)
            MODE_ERR_AT:  err = (issue_no == err_issue);
            MODE_ERR_ALL: err = 1'b1;
            MODE_NOACK:   return;
            MODE_STUCK:   begin scn_q.push_back(4'd5); return; end
            MODE_SKIP:    skip = 1'b1;
            MODE_RAND: begin
                k = $urandom_range(0, 99);
                err = (k < 15);
                skip = (k >= 15) && (k < 20);
                d = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
                k = $urandom_range(0, 6);
            end
            default: ;
        endcase
        for (int i = 0; i < d; i++) scn_q.push_back(4'd0);
        if (err) begin
            for (int c = 1; c <= k; c++) scn_q.push_back(4'(c));
            repeat ($urandom_range(1, 3)) scn_q.push_back(4'd8);
            scn_q.push_back(4'd0);
        end else begin
            for (int c = 1; c <= 7; c++) begin
                if (!(skip && c == 7)) begin
                    repeat ($urandom_range(1, 2)) scn_q.push_back(4'(c));
                end
            end
            scn_q.push_back(4'd0);
        end
    endtask

    // ---------------- per-cycle engine and compare ----------------
    int cyc = 0;
    int last_start = -1;
    int min_gap = 1000000;
    int n_start = 0;
    int n_done = 0;
    int fault_cyc = 0;
    bit prev_fault = 1'b0;

    task automatic clear_stats();
        last_start = -1; min_gap = 1000000; n_start = 0; n_done = 0; issue_no = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("cycle_outputs",
            32'({scan_start, lot_busy, lot_done, lot_fault, fault_code, wafer_idx, retry_cnt}),
            32'(expected()));
        if (lot_fault && !prev_fault) fault_cyc = cyc;
        prev_fault = lot_fault;
        if (lot_done) n_done++;
        if (scan_start) begin
            issue_no++;
            n_start++;
            if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
            last_start = cyc;
            build_seq();
        end
        if (reset) begin
            scn_q.delete();
            scan_process = 4'd0;
        end else if (scn_q.size() > 0) begin
            scan_process = scn_q.pop_front();
        end
    endtask

    task automatic start_lot(input logic [7:0] sz);
        lot_size = sz;
        lot_start = 1'b1;
        cycle();
        lot_start = 1'b0;
    endtask

    task automatic settle(input int budget, input string name);
        int k = 0;
        while (!model_settled() && k < budget) begin cycle(); k++; end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((scn_q.size() > 0 || scan_process != 4'd0) && k < budget) begin cycle(); k++; end
        chk("drain_bound", 32'(k < budget), 32'd1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; lot_start = 1'b0; lot_size = 8'd0; abort = 1'b0; scan_process = 4'd0;
        cycle();
        cycle();
        chk("reset_outputs",
            32'({scan_start, lot_busy, lot_done, lot_fault, fault_code, wafer_idx, retry_cnt}), 32'd0);
        reset = 1'b0;
        cycle();

        // normal lot of three wafers
        mode = MODE_NORMAL; clear_stats();
        start_lot(8'd3);
        settle(500, "normal_bound");
        drain(50);
        chk("normal_starts", 32'(n_start), 32'd3);
        chk("normal_done", 32'(n_done), 32'd1);
        chk("normal_idx", 32'(wafer_idx), 32'd3);
        chk("normal_fault", 32'(lot_fault), 32'd0);
        chk("normal_spacing", 32'(min_gap >= 7), 32'd1);

        // zero-size lot completes on the next cycle
        clear_stats();
        start_lot(8'd0);
        chk("zero_done", 32'(lot_done), 32'd1);
        cycle();
        chk("zero_starts", 32'(n_start), 32'd0);
        chk("zero_idx", 32'(wafer_idx), 32'd0);

        // lot_start together with abort is ignored
        lot_size = 8'd2; lot_start = 1'b1; abort = 1'b1;
        cycle();
        lot_start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(lot_busy), 32'd0);
        cycle();

        // error on wafer 2, reissued
        mode = MODE_ERR_AT; clear_stats(); err_issue = 2;
        start_lot(8'd3);
        settle(500, "retry_bound");
        drain(50);
        chk("retry_cnt", 32'(retry_cnt), 32'd1);
        chk("retry_idx", 32'(wafer_idx), 32'd3);
        chk("retry_code", 32'(fault_code), 32'd0);
        chk("retry_starts", 32'(n_start), 32'd4);

        // third error in a lot exhausts retries
        mode = MODE_ERR_ALL; clear_stats();
        start_lot(8'd3);
        settle(500, "exhaust_bound");
        drain(50);
        chk("exhaust_fault", 32'(lot_fault), 32'd1);
        chk("exhaust_code", 32'(fault_code), 32'd3);
        mode = MODE_NORMAL;
        start_lot(8'd2);
        repeat (3) cycle();
        chk("exhaust_sticky", 32'(lot_fault), 32'd1);
        chk("exhaust_no_start", 32'(n_start), 32'd3);
        pulse_abort();
        chk("abort_clear_code", 32'(fault_code), 32'd0);
        chk("abort_clear_fault", 32'(lot_fault), 32'd0);

        // acknowledge timeout
        mode = MODE_NOACK; clear_stats();
        start_lot(8'd1);
        settle(100, "ack_bound");
        chk("ack_code", 32'(fault_code), 32'd1);
        chk("ack_latency", 32'(fault_cyc - last_start), 32'd17);
        pulse_abort();

        // run timeout with scanner stuck mid-process
        mode = MODE_STUCK; clear_stats();
        start_lot(8'd1);
        settle(5000, "run_bound");
        chk("run_code", 32'(fault_code), 32'd2);
        chk("run_latency", 32'(fault_cyc - last_start), 32'd4002);
        scn_q.delete(); scan_process = 4'd0;
        pulse_abort();

        // return to IDLE without UNLOAD
        mode = MODE_SKIP; clear_stats();
        start_lot(8'd2);
        settle(200, "skip_bound");
        chk("skip_code", 32'(fault_code), 32'd4);
        pulse_abort();
        drain(50);

        // abort in the middle of a run
        mode = MODE_NORMAL; clear_stats();
        start_lot(8'd3);
        k = 0;
        while (ph != PH_BUSY && k < 50) begin cycle(); k++; end
        chk("abort_reach_run", 32'(k < 50), 32'd1);
        pulse_abort();
        chk("abort_busy", 32'(lot_busy), 32'd0);
        chk("abort_done", 32'(lot_done), 32'd0);
        drain(50);

        // synchronous reset during the inter-wafer gap
        clear_stats();
        start_lot(8'd2);
        k = 0;
        while (ph != PH_PAUSE && k < 100) begin cycle(); k++; end
        chk("reset_reach_gap", 32'(k < 100), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midlot_reset",
            32'({scan_start, lot_busy, lot_done, lot_fault, fault_code, wafer_idx, retry_cnt}), 32'd0);
        cycle();
        clear_stats();
        start_lot(8'd2);
        settle(500, "after_reset_bound");
        drain(50);
        chk("after_reset_idx", 32'(wafer_idx), 32'd2);
        chk("after_reset_done", 32'(n_done), 32'd1);

        // randomized lots against the model
        mode = MODE_RAND;
        for (int lot = 0; lot < 40; lot++) begin
            start_lot(8'($urandom_range(0, 5)));
            k = 0;
            while (!model_settled() && k < 20000) begin
                abort = ($urandom_range(0, 299) == 0);
                cycle();
                abort = 1'b0;
                k++;
            end
            chk("rand_settle", 32'(k < 20000), 32'd1);
            if (ph == PH_STUCK) begin
                lot_size = 8'd1; lot_start = 1'b1;
                cycle();
                lot_start = 1'b0;
                pulse_abort();
            end
            drain(100);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
